// File: rtl/matriz_scan_ctrl.sv
// Row-scan and image-rotation sequencer for the 7x5 LED matrix.
// Optional build macro BLINK_CRIT_EN: blinks the Crit image (img_sel 0) with an 8-frame period.
//
// state  | meaning
// IDLE   | no requests or not started; display blank, row 0
// SWITCH | one-cycle round-robin pick of the next requested image
// SHOW   | scanning rows of the selected image
module matriz_scan_ctrl #(
  parameter int SCAN_DIV    = 1000,
  parameter int HOLD_FRAMES = 50,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] req,
  output logic [2:0] sel,
  output logic [2:0] img_sel,
  output logic       blank,
  output logic       frame_start
);

  typedef enum logic [1:0] {IDLE, SWITCH, SHOW} state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] HF_LAST  = CNT_W'(HOLD_FRAMES - 1);

  state_t           state, state_nxt;
  logic [2:0]       sel_nxt, img_nxt;
  logic [CNT_W-1:0] pre_cnt, pre_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_nxt;
  logic             tick;
  logic             hit;
  logic [2:0]       pick;
  logic [3:0]       srch_idx;
  logic             blink_off;

`ifdef BLINK_CRIT_EN
  assign blink_off = (img_sel == 3'd0) && frame_cnt[2];
`else
  assign blink_off = 1'b0;
`endif

  // Prescaler is a down-counter; a row tick is its terminal count.
  assign tick = (pre_cnt == '0);

  // Round-robin search starting one past the current image, current image last.
  always_comb begin
    hit      = 1'b0;
    pick     = img_sel;
    srch_idx = '0;
    for (int k = 1; k <= 6; k++) begin
      srch_idx = {1'b0, img_sel} + 4'(k);
      if (srch_idx >= 4'd6) srch_idx = srch_idx - 4'd6;
      if (!hit && req[srch_idx[2:0]]) begin
        hit  = 1'b1;
        pick = srch_idx[2:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    img_nxt     = img_sel;
    pre_nxt     = pre_cnt;
    frame_nxt   = frame_cnt;
    blank       = 1'b1;
    frame_start = 1'b0;
    if (enable && !reset) begin
      case (state)
        IDLE: begin
          sel_nxt = 3'd0;
          pre_nxt = PRE_LAST;
          if (req != 6'd0) state_nxt = SWITCH;
        end
        SWITCH: begin
          sel_nxt = 3'd0;
          if (hit) begin
            img_nxt   = pick;
            frame_nxt = '0;
            pre_nxt   = PRE_LAST;
            state_nxt = SHOW;
          end else begin
            state_nxt = IDLE;
          end
        end
        SHOW: begin
          blank = blink_off;
          if (tick) begin
            pre_nxt = PRE_LAST;
            if (sel == 3'd6) begin
              sel_nxt     = 3'd0;
              frame_start = 1'b1;
              frame_nxt   = frame_cnt + 1'b1;
              if (frame_cnt == HF_LAST || !req[img_sel]) state_nxt = SWITCH;
            end else begin
              sel_nxt = sel + 3'd1;
            end
          end else begin
            pre_nxt = pre_cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 3'd0;
      img_sel   <= 3'd0;
      pre_cnt   <= PRE_LAST;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      img_sel   <= img_nxt;
      pre_cnt   <= pre_nxt;
      frame_cnt <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// Directed bench for matriz_scan_ctrl with SCAN_DIV=2; second instance uses HOLD_FRAMES=16.
module tb_matriz_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [5:0] req = 6'h3F;
  logic [2:0] sel, img_sel;
  logic       blank, frame_start;

  logic       reset16 = 1'b1;
  logic [5:0] req16 = 6'd0;
  logic [2:0] sel16, img_sel16;
  logic       blank16, frame_start16;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  matriz_scan_ctrl #(.SCAN_DIV(2), .HOLD_FRAMES(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .sel(sel), .img_sel(img_sel), .blank(blank), .frame_start(frame_start)
  );

  matriz_scan_ctrl #(.SCAN_DIV(2), .HOLD_FRAMES(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset16), .enable(enable), .req(req16),
    .sel(sel16), .img_sel(img_sel16), .blank(blank16), .frame_start(frame_start16)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_img[3];
    int exp_blank;
    exp_img = '{5, 2, 5};

    // 1: reset held 3 clocks
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_sel", sel, 0);
      chk("rst_img", img_sel, 0);
      chk("rst_blank", blank, 1);
      chk("rst_fs", frame_start, 0);
    end

    // 2: single request on image 2
    reset = 1'b0;
    req   = 6'b000100;
    step(1);
    chk("t2_switch_blank", blank, 1);
    step(1);
    chk("t2_show_blank", blank, 0);
    chk("t2_show_img", img_sel, 2);
    chk("t2_show_sel", sel, 0);
    for (int r = 1; r <= 6; r++) begin
      step(2);
      chk("t2_sel_step", sel, r);
      chk("t2_fs_idle", frame_start, 0);
    end
    step(1);
    chk("t2_fs_pulse1", frame_start, 1);
    step(1);
    chk("t2_sel_wrap", sel, 0);
    chk("t2_fs_low", frame_start, 0);
    chk("t2_stay_show", blank, 0);
    step(13);
    chk("t2_fs_pulse2", frame_start, 1);
    step(1);
    chk("t2_rot_blank", blank, 1);
    step(1);
    chk("t2_keep_img", img_sel, 2);
    chk("t2_reshow", blank, 0);

    // 3: alternate images 2 and 5, 29 clocks per rotation
    req = 6'b100100;
    for (int i = 0; i < 3; i++) begin
      step(28);
      chk("t3_switch_blank", blank, 1);
      step(1);
      chk("t3_img", img_sel, exp_img[i]);
      chk("t3_show_blank", blank, 0);
    end

    // 4: drop current request mid-frame, then all requests
    step(6);
    chk("t4_sel3", sel, 3);
    req = 6'b000100;
    step(6);
    chk("t4_sel6", sel, 6);
    chk("t4_not_trunc", blank, 0);
    step(1);
    chk("t4_fs", frame_start, 1);
    step(1);
    chk("t4_switch", blank, 1);
    step(1);
    chk("t4_img2", img_sel, 2);
    chk("t4_show", blank, 0);
    req = 6'd0;
    step(13);
    chk("t4_fs_last", frame_start, 1);
    chk("t4_full_frame", blank, 0);
    step(1);
    chk("t4_switch2", blank, 1);
    step(1);
    chk("t4_idle_blank", blank, 1);
    chk("t4_idle_sel", sel, 0);
    step(4);
    chk("t4_idle_stay", blank, 1);

    // 5: freeze at sel=4
    req = 6'b000100;
    step(2);
    chk("t5_show", blank, 0);
    step(8);
    chk("t5_sel4", sel, 4);
    enable = 1'b0;
    #1;
    chk("t5_blank_now", blank, 1);
    step(10);
    chk("t5_sel_held", sel, 4);
    chk("t5_img_held", img_sel, 2);
    chk("t5_blank_held", blank, 1);
    chk("t5_fs_low", frame_start, 0);
    enable = 1'b1;
    #1;
    chk("t5_resume_blank", blank, 0);
    step(2);
    chk("t5_sel5", sel, 5);

    // 6: critical image blink on the HOLD_FRAMES=16 instance
    reset16 = 1'b0;
    req16   = 6'b000001;
    step(2);
    chk("t6_img", img_sel16, 0);
    step(7);
    for (int f = 0; f < 16; f++) begin
`ifdef BLINK_CRIT_EN
      exp_blank = (f >> 2) & 1;
`else
      exp_blank = 0;
`endif
      chk("t6_blank", blank16, exp_blank);
      chk("t6_sel", sel16, 3);
      if (f < 15) step(14);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
